// File: rtl/axi_pkg.sv
// Shared AXI address-channel types, constants and the burst sizing helper
// used by the burst splitter.
package axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam int         PAGE_BYTES = 4096;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        last;
  } axi_cmd_t;

  function automatic logic [2:0] size_enc(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

  // Beats for the next burst: smallest of remaining beats, beats left before
  // the 4 KB page boundary, and the per-burst cap.
  function automatic logic [8:0] calc_burst(input logic [11:0]   page_off,
                                            input logic [31:0]   rem,
                                            input logic [8:0]    max_beats,
                                            input int unsigned   bytes_log2);
    logic [12:0] bound;
    logic [12:0] m;
    bound = (13'(PAGE_BYTES) - {1'b0, page_off}) >> bytes_log2;
    m = {4'd0, max_beats};
    if (bound < m) m = bound;
    if (rem < {19'd0, m}) m = rem[12:0];
    return m[8:0];
  endfunction

endpackage

// File: rtl/axi_burst_splitter.sv
// Splits one DMA transfer request into AXI INCR bursts that never cross a
// 4 KB page and never exceed MAX_BEATS beats.
module axi_burst_splitter
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_len,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]            cmd_len,
  output logic [2:0]            cmd_size,
  output logic [1:0]            cmd_burst,
  output logic                  cmd_last,
  output logic                  busy,
  output logic                  err_pulse,
  output logic [15:0]           err_count
);

  localparam int BL = $clog2(DATA_WIDTH / 8);
  localparam int RW = 32 - BL;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [8:0]            burst_q, burst_d;
  logic [8:0]            burst_calc;
  axi_cmd_t              cmd_q, cmd_d;
  logic                  err_pulse_q, err_pulse_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic                  req_bad;
  logic                  unused_addr_hi;

  assign req_bad    = (req_addr[BL-1:0] != '0) || (req_len == '0) || (req_len[BL-1:0] != '0);
  assign burst_calc = calc_burst(cur_addr_q[11:0], 32'(rem_q), 9'(MAX_BEATS), BL);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    rem_d       = rem_q;
    burst_d     = burst_q;
    cmd_d       = cmd_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end else begin
            cur_addr_d = req_addr;
            rem_d      = req_len[31:BL];
            state_d    = S_CALC;
          end
        end
      end
      S_CALC: begin
        cmd_d.addr = 64'(cur_addr_q);
        cmd_d.len  = 8'(burst_calc - 9'd1);
        cmd_d.last = (RW'(burst_calc) == rem_q);
        burst_d    = burst_calc;
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          cur_addr_d = cur_addr_q + (ADDR_WIDTH'(burst_q) << BL);
          rem_d      = rem_q - RW'(burst_q);
          state_d    = cmd_q.last ? S_IDLE : S_CALC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      rem_q       <= '0;
      burst_q     <= '0;
      cmd_q       <= '{addr: '0, len: '0, size: size_enc(DATA_WIDTH), burst: BURST_INCR, last: 1'b0};
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      rem_q       <= rem_d;
      burst_q     <= burst_d;
      cmd_q       <= cmd_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // req_ready is gated by rst so it reads low for the whole reset cycle.
  assign req_ready      = (state_q == S_IDLE) && !rst;
  assign busy           = (state_q != S_IDLE);
  assign cmd_valid      = (state_q == S_ISSUE);
  assign cmd_addr       = cmd_q.addr[ADDR_WIDTH-1:0];
  assign cmd_len        = cmd_q.len;
  assign cmd_size       = cmd_q.size;
  assign cmd_burst      = cmd_q.burst;
  assign cmd_last       = cmd_q.last;
  assign err_pulse      = err_pulse_q;
  assign err_count      = err_cnt_q;
  assign unused_addr_hi = ^cmd_q.addr;

endmodule

// File: doc/axi_burst_splitter.md
Name: axi_burst_splitter

Overview:
- Sits directly upstream of the AXI master write/read address channel.
- Accepts one DMA transfer request (byte address, byte length) and emits a sequence of AXI INCR burst commands (AxADDR/AxLEN/AxSIZE/AxBURST).
- No burst crosses a 4 KB page and no burst exceeds MAX_BEATS.
- Rejects misaligned or malformed requests with an error pulse instead of issuing bursts.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data bus width in bits (32/64/128); BYTES = DATA_WIDTH/8.
- MAX_BEATS, 256, max beats per burst (power of 2, 1..256).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_addr  in  ADDR_WIDTH  start byte address.
- req_len  in  32  transfer length in bytes.
- cmd_valid  out  1  burst command valid.
- cmd_ready  in  1  downstream accepts command.
- cmd_addr  out  ADDR_WIDTH  burst start address.
- cmd_len  out  8  beats-1 (AxLEN).
- cmd_size  out  3  constant log2(BYTES).
- cmd_burst  out  2  constant 2'b01 (INCR).
- cmd_last  out  1  final burst of current request.
- busy  out  1  high in any state other than IDLE.
- err_pulse  out  1  one-cycle pulse when a request is rejected.
- err_count  out  16  saturating count of rejected requests.

Behaviour:
- Reset values: req_ready=0, cmd_valid=0, cmd_addr=0, cmd_len=0, cmd_last=0, busy=0, err_pulse=0, err_count=0, FSM=IDLE.
  - Reset asserted mid-transfer abandons the remaining bursts; no partial command survives.
- FSM states: IDLE, CALC, ISSUE.
- IDLE: req_ready=1.
  - On req_valid, check the request.
  - Reject if req_addr[log2(BYTES)-1:0]!=0, req_len==0, or req_len[log2(BYTES)-1:0]!=0.
  - Reject action: err_pulse=1 next cycle, err_count++ (saturating at 16'hFFFF), remain in IDLE, no command issued.
  - Otherwise latch cur_addr=req_addr and rem_beats=req_len/BYTES (width 32-log2(BYTES)), then go to CALC.
- CALC (1 cycle):
  - bound_beats = (4096 - cur_addr[11:0]) / BYTES, computed with 13-bit arithmetic; at offset 0 the result is 4096/BYTES.
  - burst = min(rem_beats, bound_beats, MAX_BEATS).
  - Register cmd_addr=cur_addr, cmd_len=burst-1, cmd_last=(burst==rem_beats).
  - Go to ISSUE.
- ISSUE: cmd_valid=1.
  - cmd_addr, cmd_len, and cmd_last are held stable until cmd_ready.
  - On handshake: cur_addr += burst*BYTES and rem_beats -= burst.
  - If cmd_last, go to IDLE; otherwise go to CALC.
- Latency: request accepted in cycle N gives the first cmd_valid in cycle N+2. Each subsequent burst takes at least 2 cycles (1 bubble).
- req_ready is 0 outside IDLE. A new request is never accepted in the same cycle as the final command handshake.
- Address wrap past 2^ADDR_WIDTH is not checked; it wraps modulo.

Decomposition:
- Shared package axi_pkg holds:
  - BURST_INCR=2'b01, PAGE_BYTES=4096.
  - Function size_enc(DATA_WIDTH).
  - typedef axi_cmd_t {addr, len, size, burst, last}.
- No sub-module is needed. The min/boundary computation is a combinational function in the package: calc_burst(addr, rem, max).

Test Plan:
- addr 0x1000, len 64, cmd_ready=1 -> one command: addr 0x1000, len 15, last=1; first cmd_valid 2 cycles after the request handshake.
- addr 0x0FF0, len 64 -> two commands: (0x0FF0, len 3, last=0) then (0x1000, len 11, last=1).
- addr 0x0, len 2048 -> (0x000, len 255, last=0) then (0x400, len 255, last=1).
- addr 0x1002 len 16, then addr 0x2000 len 0 -> two err_pulse cycles, err_count=2, cmd_valid never asserted, req_ready stays 1.
- Same as the second scenario with cmd_ready held low 5 cycles on the first command -> cmd_valid/addr/len stable for those cycles; the sequence is otherwise unchanged.
- Assert rst for 1 cycle while in ISSUE of a 3-burst request -> next cycle cmd_valid=0, busy=0, req_ready=0 during reset and 1 after; a fresh request afterwards behaves as in the first scenario.
